logic_op_pipe: RTL and testbench



---
 rtl/logic_op_pkg.sv | 31 +++
 rtl/logic_op_core.sv | 20 ++
 rtl/logic_op_pipe.sv | 133 +++++++++++++
 tb/tb_logic_op_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// rtl/logic_op_pkg.sv - op encoding and single-bit logic function shared by the pipe
package logic_op_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_AND  = 3'd0;
   localparam op_t OP_OR   = 3'd1;
   localparam op_t OP_XOR  = 3'd2;
   localparam op_t OP_NAND = 3'd3;
   localparam op_t OP_NOR  = 3'd4;
   localparam op_t OP_XNOR = 3'd5;
   localparam op_t OP_PASA = 3'd6;
   localparam op_t OP_NOTA = 3'd7;

   // One gate of the old fixed-function blocks, selected by op.
   function automatic logic logic_op_bit(input logic x, input logic y, input op_t op);
      logic r;
      case (op)
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_XOR:  r = x ^ y;
         OP_NAND: r = ~(x & y);
         OP_NOR:  r = ~(x | y);
         OP_XNOR: r = ~(x ^ y);
         OP_PASA: r = x;
         default: r = ~x;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_op_core.sv
// rtl/logic_op_core.sv - combinational WIDTH-bit bitwise logic unit
module logic_op_core
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  op_t              op,
   output logic [WIDTH-1:0] res
);

   always_comb begin
      res = '0;
      for (int i = 0; i < WIDTH; i++) begin
         res[i] = logic_op_bit(x[i], y[i], op);
      end
   end

endmodule

// File: rtl/logic_op_pipe.sv
// rtl/logic_op_pipe.sv - two-stage pipelined logic unit with accumulator, flags and counter
module logic_op_pipe
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             parity,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] count
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   op_t              s1_op_q, s1_op_d;
   logic             s1_acc_en_q, s1_acc_en_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic             parity_q, parity_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             s2_adv, s1_adv, in_fire, out_fire;
   logic [WIDTH-1:0] core_x, core_y, core_res;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = s1_valid_q && s2_adv;
   assign in_ready = !s1_valid_q || s2_adv;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = s2_valid_q && out_ready;

   // Accumulate mode feeds acc in as the first operand and a as the second.
   assign core_x = s1_acc_en_q ? acc_q : s1_a_q;
   assign core_y = s1_acc_en_q ? s1_a_q : s1_b_q;

   logic_op_core #(.WIDTH(WIDTH)) u_core (
      .x   (core_x),
      .y   (core_y),
      .op  (s1_op_q),
      .res (core_res)
   );

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_op_d     = s1_op_q;
      s1_acc_en_d = s1_acc_en_q;
      s2_valid_d  = s2_valid_q;
      y_d         = y_q;
      zero_d      = zero_q;
      parity_d    = parity_q;
      acc_d       = acc_q;
      count_d     = count_q + CNT_W'(out_fire);

      if (in_fire) begin
         s1_valid_d  = 1'b1;
         s1_a_d      = a;
         s1_b_d      = b;
         s1_op_d     = op;
         s1_acc_en_d = acc_en;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
         s2_valid_d = 1'b1;
         y_d        = core_res;
         zero_d     = (core_res == '0);
         parity_d   = ^core_res;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end

      // Clear has priority over an accumulate write in the same cycle.
      if (acc_clr) begin
         acc_d = '0;
      end else if (s1_adv && s1_acc_en_q) begin
         acc_d = core_res;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= OP_AND;
         s1_acc_en_q <= 1'b0;
         s2_valid_q  <= 1'b0;
         y_q         <= '0;
         zero_q      <= 1'b1;
         parity_q    <= 1'b0;
         acc_q       <= '0;
         count_q     <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_op_q     <= s1_op_d;
         s1_acc_en_q <= s1_acc_en_d;
         s2_valid_q  <= s2_valid_d;
         y_q         <= y_d;
         zero_q      <= zero_d;
         parity_q    <= parity_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign y         = y_q;
   assign zero      = zero_q;
   assign parity    = parity_q;
   assign acc       = acc_q;
   assign count     = count_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb/tb_logic_op_pipe.sv - scoreboard bench for logic_op_pipe with truth-table reference model
module tb_logic_op_pipe;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  a, b;
   logic [2:0]    op;
   logic          acc_en, acc_clr;
   logic          out_valid, out_ready;
   logic [W-1:0]  y;
   logic          zero, parity;
   logic [W-1:0]  acc;
   logic [CW-1:0] count;

   logic_op_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .acc_en    (acc_en),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .zero      (zero),
      .parity    (parity),
      .acc       (acc),
      .count     (count)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] m_acc    = 8'h00;
   int         exp_cnt  = 0;
   bit         mon_en   = 1'b0;
   bit         bp_en    = 1'b0;
   logic [3:0] tt[8];
   logic [7:0] t1_exp[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Per-bit truth table lookup, indexed by {x, y}.
   function automatic logic [7:0] model_f(input logic [7:0] x, input logic [7:0] yy, input int o);
      logic [7:0] r;
      logic [3:0] t;
      t = tt[o];
      for (int i = 0; i < 8; i++) r[i] = t[{x[i], yy[i]}];
      return r;
   endfunction

   task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input int top,
                       input bit ten, input bit has_exp, input logic [7:0] ey);
      logic [7:0] r;
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      a        = ta;
      b        = tb_v;
      op       = 3'(top);
      acc_en   = ten;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stuck at %0d, required 1", in_ready);
         in_valid = 1'b0;
      end else begin
         r = ten ? model_f(m_acc, ta, top) : model_f(ta, tb_v, top);
         if (has_exp) r = ey;
         if (ten) m_acc = r;
         exp_q.push_back(r);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      acc_clr = 1'b1;
      @(posedge clk);
      #1;
      acc_clr = 1'b0;
      m_acc   = 8'h00;
   endtask

   // Scoreboard monitor: compares every presented result and pops on handshake.
   always @(negedge clk) begin
      if (mon_en && rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: y=0x%0h with empty scoreboard", y);
         end else begin
            chk("y", y, exp_q[0]);
            chk("zero", zero, exp_q[0] == 8'h00);
            chk("parity", parity, $countones(exp_q[0]) % 2);
            if (out_ready) begin
               chk("count", count, exp_cnt % 16);
               exp_cnt++;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         if (bp_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0;
      tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
      tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b1100; tt[7] = 4'b0011;
      t1_exp[0] = 8'h30; t1_exp[1] = 8'hFC; t1_exp[2] = 8'hCC; t1_exp[3] = 8'hCF;
      t1_exp[4] = 8'h03; t1_exp[5] = 8'h33; t1_exp[6] = 8'hF0; t1_exp[7] = 8'h0F;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
      acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y", y, 0);
      chk("rst_zero", zero, 1);
      chk("rst_parity", parity, 0);
      chk("rst_acc", acc, 0);
      chk("rst_count", count, 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      for (int o = 0; o < 8; o++) send(8'hF0, 8'h3C, o, 1'b0, 1'b1, t1_exp[o]);
      drain();

      clr();
      c0 = exp_cnt;
      send(8'h01, 8'h00, 1, 1'b1, 1'b1, 8'h01);
      send(8'h02, 8'h00, 1, 1'b1, 1'b1, 8'h03);
      send(8'h04, 8'h00, 1, 1'b1, 1'b1, 8'h07);
      drain();
      chk("chain_acc", acc, 8'h07);
      chk("chain_count", count, (c0 + 3) % 16);

      out_ready = 1'b0;
      send(8'h11, 8'h00, 6, 1'b0, 1'b0, 8'h00);
      send(8'h22, 8'h00, 6, 1'b0, 1'b0, 8'h00);
      in_valid = 1'b1; a = 8'h33; op = 3'd6; acc_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_y_hold", y, 8'h11);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(8'h33, 8'h00, 6, 1'b0, 1'b0, 8'h00);
      drain();

      clr();
      send(8'hAA, 8'h00, 1, 1'b1, 1'b1, 8'hAA);
      drain();
      chk("pre_collision_acc", acc, 8'hAA);
      send(8'hFF, 8'h00, 2, 1'b1, 1'b1, 8'h55);
      acc_clr = 1'b1;
      @(posedge clk);
      #1;
      acc_clr = 1'b0;
      m_acc   = 8'h00;
      drain();
      chk("collision_acc", acc, 8'h00);

      send(8'h0F, 8'hF0, 0, 1'b0, 1'b1, 8'h00);
      drain();
      c0 = exp_cnt;
      for (int k = 0; k < 16; k++) send(8'($urandom), 8'($urandom), 6, 1'b0, 1'b0, 8'h00);
      drain();
      chk("wrap_count", count, c0 % 16);

      bp_en = 1'b1;
      for (int k = 0; k < 150; k++) begin
         send(8'($urandom), 8'($urandom), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'b0, 8'h00);
      end
      drain();
      bp_en = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      chk("random_acc", acc, m_acc);

      out_ready = 1'b0;
      send(8'h01, 8'h00, 6, 1'b0, 1'b0, 8'h00);
      send(8'h02, 8'h00, 6, 1'b0, 1'b0, 8'h00);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_count", count, 0);
      chk("midrst_acc", acc, 0);
      chk("midrst_in_ready", in_ready, 1);
      exp_q.delete();
      exp_cnt = 0;
      m_acc   = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      mon_en    = 1'b1;
      send(8'h0F, 8'hFF, 0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("lat_edge1_out_valid", out_valid, 0);
      @(negedge clk);
      chk("lat_edge2_out_valid", out_valid, 1);
      drain();
      chk("post_rst_count", count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
